// File: rtl/matrix_stream_loader.sv
// Packs a serial DW-bit element stream into two row-major NxN operand buses (A then B).
// Optional in_last framing check is enabled by defining MATRIX_LOADER_FRAME_CHECK_EN.
module matrix_stream_loader #(
  parameter int unsigned DW = 16,
  parameter int unsigned N  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [N*N*DW-1:0] matrix_A,
  output logic [N*N*DW-1:0] matrix_B,
  output logic              mat_valid,
  input  logic              mat_ready,
  output logic              frame_err
);

  localparam int unsigned NE = N * N;
  localparam int unsigned IW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          accept;
  logic          last_slot;
  logic          early_last;
  logic          wr_a;
  logic          wr_b;

  // Ready is a pure decode of state so the upstream sees it even during reset.
  assign in_ready  = (state != HOLD);
  assign accept    = in_valid && in_ready;
  assign last_slot = (idx == LAST_IDX);
  assign wr_a      = accept && !flush && (state == LOAD_A);
  assign wr_b      = accept && !flush && (state == LOAD_B);

`ifdef MATRIX_LOADER_FRAME_CHECK_EN
  logic frame_end;
  logic missing_last;

  assign frame_end    = (state == LOAD_B) && last_slot;
  assign early_last   = accept && in_last && !frame_end;
  assign missing_last = accept && !in_last && frame_end;

  // One-cycle error pulse; a flushed element is dropped and never checked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= !flush && (early_last || missing_last);
    end
  end
`else
  logic unused_in_last;

  assign early_last     = 1'b0;
  assign unused_in_last = in_last;
  assign frame_err      = 1'b0;
`endif

  // Frame sequencer: flush outranks both element accept and the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD_A;
      idx       <= '0;
      mat_valid <= 1'b0;
    end else if (flush) begin
      state     <= LOAD_A;
      idx       <= '0;
      mat_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (accept) begin
            if (early_last) begin
              idx <= '0;
            end else if (last_slot) begin
              state <= LOAD_B;
              idx   <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (early_last) begin
              state <= LOAD_A;
              idx   <= '0;
            end else if (last_slot) begin
              state     <= HOLD;
              idx       <= '0;
              mat_valid <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        HOLD: begin
          if (mat_ready) begin
            state     <= LOAD_A;
            mat_valid <= 1'b0;
          end
        end
        default: begin
          state     <= LOAD_A;
          idx       <= '0;
          mat_valid <= 1'b0;
        end
      endcase
    end
  end

  // Operand buses: slot k lands in [(NE-k)*DW-1 -: DW]; old slots persist until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matrix_A <= '0;
      matrix_B <= '0;
    end else begin
      for (int unsigned k = 0; k < NE; k++) begin
        if (idx == IW'(k)) begin
          if (wr_a) matrix_A[(NE - k) * DW - 1 -: DW] <= in_data;
          if (wr_b) matrix_B[(NE - k) * DW - 1 -: DW] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: frame table plus scoreboard, with flush/reset/framing sequences.
module tb_matrix_stream_loader;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 3;
  localparam int unsigned BW = N * N * DW;
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  typedef struct {
    logic [DW-1:0] first;
    bit            down;
    int            gap_pct;
    int            hold;
    bit            b2b;
    logic [BW-1:0] exp_a;
    logic [BW-1:0] exp_b;
  } vec_t;

  typedef struct {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [BW-1:0] matrix_A;
  logic [BW-1:0] matrix_B;
  logic          mat_valid;
  logic          mat_ready;
  logic          frame_err;

  vec_t vecs[5];
  exp_t sbq[$];
  int   rise_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   hold_cfg = 0;
  int   err_cycles = 0;
  int   last_acc_cyc = 0;
  bit   seen_valid = 1'b0;

  matrix_stream_loader #(.DW(DW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .matrix_A(matrix_A), .matrix_B(matrix_B),
    .mat_valid(mat_valid), .mat_ready(mat_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] elem(input vec_t v, input int k);
    return v.down ? v.first - DW'(k) : v.first + DW'(k);
  endfunction

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.a = v.exp_a;
    e.b = v.exp_b;
    sbq.push_back(e);
  endtask

  // Holds the current element until the loader takes it; bounded.
  task automatic wait_accept();
    bit done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept, expected accept within 200 cycles");
    end
    last_acc_cyc = cyc;
  endtask

  task automatic send_raw(input logic [DW-1:0] d, input bit last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic send_frame(input vec_t v, input int nelem, input int last_at);
    for (int k = 0; k < nelem; k++) begin
      if (v.gap_pct > 0 && $urandom_range(99) < 32'(v.gap_pct)) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_raw(elem(v, k), k == last_at);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sbq.size() != 0 || mat_valid || seen_valid) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      n_vec++;
      n_fail++;
      $display("FAIL idle_timeout: got pending=%0d, expected 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Consumer: hold mat_ready low for hold_cfg cycles of a presented frame, else high.
  initial begin
    int wait_cnt = 0;
    mat_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && mat_valid) begin
        if (wait_cnt >= hold_cfg) begin
          mat_ready = 1'b1;
        end else begin
          mat_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mat_ready = 1'b1;
        wait_cnt  = 0;
      end
    end
  end

  // Output monitor: pops the scoreboard on each new frame, checks hold and release.
  initial begin
    exp_t cur;
    bit   prev_hs = 1'b0;
    bit   prev_hold = 1'b0;
    cur.a = '0;
    cur.b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen_valid = 1'b0;
        prev_hs    = 1'b0;
        prev_hold  = 1'b0;
      end else begin
        if (frame_err) err_cycles++;
        if (prev_hs) chk("release", BW'({mat_valid, in_ready}), BW'(2'b01));
        else if (prev_hold) chk("hold_valid", BW'(mat_valid), BW'(1'b1));
        if (mat_valid && !seen_valid) begin
          rise_q.push_back(cyc);
          if (sbq.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_frame: got mat_valid=1, expected no frame");
          end else begin
            cur = sbq.pop_front();
          end
        end
        if (mat_valid) begin
          chk("frame_a", matrix_A, cur.a);
          chk("frame_b", matrix_B, cur.b);
          chk("hold_ready", BW'(in_ready), BW'(1'b0));
        end
        seen_valid = mat_valid;
        prev_hs    = mat_valid && mat_ready && !flush;
        prev_hold  = mat_valid && !mat_ready && !flush;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int first_acc;
    vecs[0] = '{16'h0001, 1'b0, 0, 0, 1'b0,
                144'h0001_0002_0003_0004_0005_0006_0007_0008_0009,
                144'h000A_000B_000C_000D_000E_000F_0010_0011_0012};
    vecs[1] = '{16'h0001, 1'b0, 0, 10, 1'b0,
                144'h0001_0002_0003_0004_0005_0006_0007_0008_0009,
                144'h000A_000B_000C_000D_000E_000F_0010_0011_0012};
    vecs[2] = '{16'hFFFF, 1'b1, 50, 2, 1'b0,
                144'hFFFF_FFFE_FFFD_FFFC_FFFB_FFFA_FFF9_FFF8_FFF7,
                144'hFFF6_FFF5_FFF4_FFF3_FFF2_FFF1_FFF0_FFEF_FFEE};
    vecs[3] = '{16'h1000, 1'b0, 0, 0, 1'b1,
                144'h1000_1001_1002_1003_1004_1005_1006_1007_1008,
                144'h1009_100A_100B_100C_100D_100E_100F_1010_1011};
    vecs[4] = '{16'hABC0, 1'b0, 0, 0, 1'b0,
                144'hABC0_ABC1_ABC2_ABC3_ABC4_ABC5_ABC6_ABC7_ABC8,
                144'hABC9_ABCA_ABCB_ABCC_ABCD_ABCE_ABCF_ABD0_ABD1};

    #3;
    chk("reset_a", matrix_A, '0);
    chk("reset_b", matrix_B, '0);
    chk("reset_flags", BW'({mat_valid, frame_err, in_ready}), BW'(3'b001));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    first_acc = 0;
    for (int i = 0; i < 5; i++) begin
      hold_cfg = vecs[i].hold;
      push_exp(vecs[i]);
      send_frame(vecs[i], 18, 17);
      if (i == 0) first_acc = last_acc_cyc;
      if (!vecs[i].b2b) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_idle();
      end
      if (i == 0) begin
        if (rise_q.size() > 0) chk("latency", BW'(rise_q[0]), BW'(first_acc));
        else chk("latency", BW'(0), BW'(first_acc));
      end
    end
    if (rise_q.size() >= 2) chk("b2b_period", BW'(rise_q[$] - rise_q[$-1]), BW'(19));
    else chk("b2b_period", BW'(rise_q.size()), BW'(2));

    // Flush after a partial frame; the element offered with flush must be dropped.
    hold_cfg = 0;
    for (int k = 0; k < 5; k++) send_raw(16'hDEA0 + DW'(k), 1'b0);
    flush    = 1'b1;
    in_data  = 16'hBAD0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    push_exp(vecs[2]);
    send_frame(vecs[2], 18, 17);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_idle();

    // Asynchronous reset mid-frame clears buses without waiting for a clock edge.
    for (int k = 0; k < 7; k++) send_raw(16'h7700 + DW'(k), 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_a", matrix_A, '0);
    chk("rst_mid_b", matrix_B, '0);
    chk("rst_mid_flags", BW'({mat_valid, in_ready}), BW'(2'b01));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp(vecs[0]);
    send_frame(vecs[0], 18, 17);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_idle();

    // Framing: early in_last on element 7, then a full frame without in_last.
    e0 = err_cycles;
    for (int k = 0; k < 7; k++) send_raw(16'h5500 + DW'(k), k == 6);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("err_early", BW'(err_cycles - e0), BW'(ERR_ON));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    hold_cfg = vecs[1].hold;
    push_exp(vecs[1]);
    send_frame(vecs[1], 18, -1);
    in_valid = 1'b0;
    wait_idle();
    chk("err_total", BW'(err_cycles - e0), BW'(2 * ERR_ON));
    chk("sb_empty", BW'(sbq.size()), BW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
